// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding and well-known command bytes.
// Imported by the host transmitter and the scan-code receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 3-flop synchronizer and edge detect for the PS/2 clock/data pins; 2-3 cycle latency.
// No backpressure: edge strobes are single-cycle and are lost if the consumer ignores them.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o,
    output logic clk_rise_o,
    output logic data_fall_o,
    output logic data_rise_o
);

    logic [2:0] clk_sync_q;
    logic [2:0] data_sync_q;

    // Lines idle high through their pull-ups, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[1:0], ps2_data_i};
        end
    end

    assign clk_s_o     = clk_sync_q[1];
    assign data_s_o    = data_sync_q[1];
    assign clk_fall_o  = (clk_sync_q[2:1] == 2'b10);
    assign clk_rise_o  = (clk_sync_q[2:1] == 2'b01);
    assign data_fall_o = (data_sync_q[2:1] == 2'b10);
    assign data_rise_o = (data_sync_q[2:1] == 2'b01);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11 device clocks, ACK check.
// Accepts one byte when idle (tx_ready_o); tx_valid_i is ignored until done_o/err_o returns it to idle.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic clk_s, data_s, clk_fall, clk_rise, data_fall, data_rise;
    logic unused_edges;

    ps2_line_sync u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_s_o     (clk_s),
        .data_s_o    (data_s),
        .clk_fall_o  (clk_fall),
        .clk_rise_o  (clk_rise),
        .data_fall_o (data_fall),
        .data_rise_o (data_rise)
    );

    assign unused_edges = clk_rise ^ data_fall ^ data_rise;

    ps2_state_e       state_q, state_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             cur_bit_q, cur_bit_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            cur_bit_q <= 1'b1;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            cur_bit_q <= cur_bit_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign timeout = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        cur_bit_d = cur_bit_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    shift_d   = {1'b1, odd_parity(tx_data_i), tx_data_i};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) state_d = ST_REQ;
                else                       inh_cnt_d = inh_cnt_q + 1'b1;
            end
            ST_REQ: begin
                to_cnt_d  = '0;
                cur_bit_d = 1'b0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    // Shift register is LSB-first: data[0..7], parity, stop.
                    if (clk_fall) begin
                        cur_bit_d = shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (clk_fall) begin
                        ack_d   = ~data_s;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (clk_s && data_s) begin
                        done_d  = ack_q;
                        err_d   = ~ack_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset releases the lines at once.
    assign tx_ready_o    = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign ps2_clk_oe_o  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2_data_oe_o = (state_q == ST_REQ) || ((state_q == ST_SEND) && !cur_bit_q);
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: a PS/2 device model clocks frames out of ps2_host_tx and checks bits, ACK handling,
// timeout, async reset and tx_valid hold-off against constant tables and a parity-counting reference.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 50;
    localparam int TO  = 2000;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, clk_oe, data_oe, busy, done, err;
    logic       dev_clk, dev_data;
    logic       ps2_clk_w, ps2_data_w;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_w  = dev_clk & ~clk_oe;
    assign ps2_data_w = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .ps2_clk_i    (ps2_clk_w),
        .ps2_data_i   (ps2_data_w),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit prev_done = 1'b0;
    bit busy_after_done = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (prev_done && busy === 1'b1) busy_after_done = 1'b1;
        prev_done = (done === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame as the device sees it, LSB-first: 8 data bits, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int  ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic send_start(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        check("ready_before_send", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_req(output int inh, output bit seen);
        inh  = 0;
        seen = 1'b0;
        for (int k = 0; k < INH + 20; k++) begin
            if (clk_oe && data_oe) begin
                seen = 1'b1;
                break;
            end
            if (clk_oe) inh++;
            @(negedge clk);
        end
    endtask

    task automatic clock_bit(output logic b);
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        b = ps2_data_w;
    endtask

    task automatic device_frame(input bit ack, output int inh, output logic [9:0] bits,
                                output bit got_done, output bit got_err);
        bit   seen;
        logic b;
        got_done = 1'b0;
        got_err  = 1'b0;
        bits     = '0;
        wait_req(inh, seen);
        check("req_seen", seen, 1);
        if (!seen) return;
        @(negedge clk);
        check("start_bit_lines", {clk_oe, data_oe}, 2'b01);
        for (int i = 0; i < 10; i++) begin
            clock_bit(b);
            bits[i] = b;
        end
        repeat (H/2) @(negedge clk);
        if (ack) dev_data = 1'b0;
        repeat (H/2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == H/2) dev_data = 1'b1;
            if (done) begin got_done = 1'b1; break; end
            if (err)  begin got_err  = 1'b1; break; end
        end
        dev_data = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                             input logic [9:0] exp_bits, input bit exp_done, input bit exp_err);
        int d0, e0, inh;
        logic [9:0] bits;
        bit gd, ge;
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(b);
        device_frame(ack, inh, bits, gd, ge);
        repeat (5) @(negedge clk);
        check({tag, ".inhibit_len"}, inh, INH);
        check({tag, ".frame_bits"}, bits, exp_bits);
        check({tag, ".done_pulses"}, done_cnt - d0, exp_done);
        check({tag, ".err_pulses"}, err_cnt - e0, exp_err);
        check({tag, ".lines_released"}, {clk_oe, data_oe}, 2'b00);
        check({tag, ".ready_not_busy"}, {tx_ready, busy}, 2'b10);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_bits;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t       tbl[5];
        int         inh, d0, e0, k_err;
        bit         seen, gd, ge;
        logic [9:0] bits;
        logic       b;
        logic [7:0] rb;
        bit         rack;

        tbl[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 10'h201, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 10'h300, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 10'h3FF, 1'b1, 1'b0};
        tbl[4] = '{8'hF4, 1'b0, 10'h2F4, 1'b0, 1'b1};

        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        #1;
        check("reset_outputs", {tx_ready, clk_oe, data_oe, busy, done, err}, 6'b100000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].ack,
                      tbl[i].exp_bits, tbl[i].exp_done, tbl[i].exp_err);

        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", i), rb, rack, ref_frame(rb), rack, !rack);
        end

        // Device never clocks: err must land exactly TO cycles after the first SEND cycle.
        e0 = err_cnt;
        send_start(PS2_CMD_RESET);
        wait_req(inh, seen);
        check("timeout.req_seen", seen, 1);
        @(negedge clk);
        k_err = -1;
        for (int k = 1; k < TO + 20; k++) begin
            @(negedge clk);
            if (err) begin
                k_err = k;
                check("timeout.lines_released", {clk_oe, data_oe}, 2'b00);
                check("timeout.ready", tx_ready, 1);
                break;
            end
        end
        check("timeout.cycles", k_err, TO);
        repeat (3) @(negedge clk);
        check("timeout.err_pulses", err_cnt - e0, 1);

        // Async reset mid-SEND after the 4th bit, while data is actively driven low.
        send_start(8'h00);
        wait_req(inh, seen);
        @(negedge clk);
        for (int i = 0; i < 4; i++) clock_bit(b);
        repeat (2) @(negedge clk);
        check("rst.pre_data_oe", data_oe, 1);
        #2 rst_n = 1'b0;
        #1 check("rst.async_release", {clk_oe, data_oe, busy, tx_ready}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_frame("after_rst", PS2_CMD_ENABLE, 1'b1, 10'h2F4, 1'b1, 1'b0);

        // tx_valid held with new data: second byte accepted on the done cycle only.
        d0 = done_cnt;
        busy_after_done = 1'b0;
        @(negedge clk);
        tx_data  = PS2_CMD_SET_LED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = PS2_CMD_RESET;
        device_frame(1'b1, inh, bits, gd, ge);
        check("held.first_bits", bits, 10'h3ED);
        check("held.first_done", gd, 1);
        check("held.ready_at_done", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(1'b1, inh, bits, gd, ge);
        repeat (5) @(negedge clk);
        check("held.second_inhibit", inh, INH);
        check("held.second_bits", bits, 10'h3FF);
        check("held.accept_on_done", busy_after_done, 1);
        check("held.done_pulses", done_cnt - d0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the open-drain PS/2 clock/data pair. It is the send-direction companion of the scan-code receiver and shares the same ps2_clk/ps2_data pins. It runs the inhibit/request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device ACK.

Parameters:
INHIBIT_CYCLES, 5000, number of clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum clk cycles from release of clock to end of ACK (15 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
tx_data  in  8  byte to send; sampled on the accept cycle
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid & tx_ready
ps2_clk  in  1  PS/2 clock pin value (asynchronous)
ps2_data  in  1  PS/2 data pin value (asynchronous)
ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (pull-up)
ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release
busy  out  1  high from accept until return to IDLE; the receiver ignores the lines while busy
done  out  1  one-cycle pulse: frame sent and ACK received
err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (rst=0, async): state IDLE; tx_ready=1; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0; counters cleared. Lines are released immediately, even mid-frame.
- Input sync: ps2_clk and ps2_data pass through a 3-flop shift register. Falling edge = sync[2:1]==2'b10; rising edge = 2'b01.
- Accept: in IDLE with tx_valid=1, latch the shift register as {stop=1, parity, tx_data}. Parity is odd: parity = ~^tx_data. Clear bit counter; go to INHIBIT next cycle. tx_valid is ignored outside IDLE.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: ps2_clk_oe=1 and ps2_data_oe=1 for one cycle (start bit = 0), then SEND. Clear the timeout counter.
- SEND: ps2_clk_oe=0. ps2_data_oe = ~current bit; the start bit holds until the first falling edge.
  - Falling edge n (n=1..8): present tx_data[n-1].
  - Falling edge 9: present parity.
  - Falling edge 10: present stop (data_oe=0), then go to ACK.
  - Bits change only on synchronized falling edges.
- ACK: on the next falling edge (11th), sample sync ps2_data. 0 = ACK (go to WAIT_IDLE with ack flag set); 1 = NACK (go to WAIT_IDLE with ack flag clear).
- WAIT_IDLE: wait until both synchronized lines are high. Then pulse done (if ACK) or err (if NACK) for one cycle and return to IDLE.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1:
  - both oe outputs go to 0 the next cycle;
  - err pulses;
  - state goes to IDLE.
  - Timeout has priority over a simultaneous edge.
- Glitches: falling edges in IDLE and INHIBIT are ignored.
- Counter widths: $clog2 of their parameter. The bit counter is 4 bits.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4;
  - PS2_ACK_BYTE=8'hFA.
- One sub-module, ps2_line_sync: 3-flop synchronizer plus rise/fall edge detect for clock and data. It is also reused by the receiver.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs -> clk_oe low for 5000 cycles; data bits seen by the device are 1,0,1,1,0,1,1,1 with parity 1 and stop 1; done pulses once; err=0.
- Send 0x01, 0x00 and 0xFF -> parity bits sampled are 0, 1 and 1 respectively; each transfer ends with done.
- Device leaves data high on the 11th clock -> err pulses; done stays 0; both oe outputs are 0; tx_ready returns to 1.
- Device never clocks after REQ -> err pulses exactly TIMEOUT_CYCLES cycles after entering SEND; lines are released.
- Assert rst=0 mid-SEND after bit 4 -> ps2_clk_oe=ps2_data_oe=0 and busy=0 within the same cycle (async); the next transfer after reset completes normally.
- tx_valid held high during a transfer with different data -> the second byte is accepted only after done, on the first cycle tx_ready=1.
